// File: rtl/npu_img_pkg.sv
// Image geometry and pixel helpers shared by the NPU input and output stages.
// The saturation helper maps a signed NPU result onto an unsigned 8-bit pixel.
package npu_img_pkg;

    localparam int IMG_W       = 640;
    localparam int IMG_H       = 480;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = IMG_W * IMG_H / 8;

    // Clamp to [0,255]: negative -> 0x00, anything above 255 -> 0xFF.
    function automatic logic [7:0] sat_u8(input logic signed [DATA_W-1:0] value);
        logic [7:0] result;
        if (value[DATA_W-1]) begin
            result = 8'h00;
        end else if (|value[DATA_W-2:8]) begin
            result = 8'hFF;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Collects saturated pixels into a 64-bit word with per-byte valid mask and
// emits a registered RAM write when the top requests a flush.
module byte_lane_packer
    import npu_img_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          flush,
    input  logic [2:0]    lane,
    input  logic [7:0]    pixel,
    input  logic [AW-1:0] word_addr,
    output logic [7:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [63:0]   ram_din
);

    logic [63:0]   pack_r;
    logic [7:0]    mask_r;
    logic [63:0]   merged_data_s;
    logic [7:0]    merged_mask_s;
    logic [7:0]    ram_we_r;
    logic [AW-1:0] ram_addr_r;
    logic [63:0]   ram_din_r;

    // Current word with the incoming pixel merged into its lane.
    always_comb begin
        merged_data_s                     = pack_r;
        merged_data_s[{lane, 3'b000} +: 8] = pixel;
        merged_mask_s                     = mask_r | (8'h01 << lane);
    end

    // Pack register and write port; a flush writes the merged word and empties the pack.
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_r     <= 64'h0;
            mask_r     <= 8'h00;
            ram_we_r   <= 8'h00;
            ram_addr_r <= '0;
            ram_din_r  <= 64'h0;
        end else begin
            ram_we_r <= 8'h00;
            if (valid) begin
                if (flush) begin
                    ram_we_r   <= merged_mask_s;
                    ram_addr_r <= word_addr;
                    ram_din_r  <= merged_data_s;
                    pack_r     <= 64'h0;
                    mask_r     <= 8'h00;
                end else begin
                    pack_r <= merged_data_s;
                    mask_r <= merged_mask_s;
                end
            end
        end
    end

    assign ram_we   = ram_we_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;

endmodule

// File: rtl/npu_output_collector.sv
// Drains the NPU output FIFO, saturates each result to a pixel and writes it to
// its raster byte position in the 64-bit result frame RAM.
module npu_output_collector
    import npu_img_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 32,
    parameter int AW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              output_fifo_empty,
    input  logic [DATA_W-1:0] output_fifo_data,
    output logic              output_fifo_rd_en,
    output logic [7:0]        ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [63:0]       ram_din,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int BW = AW + 3;

    localparam logic [CW-1:0] COL_FIRST = CW'(1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          rd_valid_r;
    logic          frame_done_r;
    logic          rd_en_s;
    logic [BW-1:0] byte_addr_s;
    logic [2:0]    lane_s;
    logic [AW-1:0] word_addr_s;
    logic          last_col_s;
    logic          last_row_s;
    logic          flush_s;
    logic [7:0]    pixel_s;

    assign rd_en_s           = ~reset & ~output_fifo_empty;
    assign output_fifo_rd_en = rd_en_s;

    // Raster address of the pixel whose result is arriving this cycle.
    always_comb begin
        byte_addr_s = BW'(row_r) * BW'(IMG_W) + BW'(col_r);
        lane_s      = byte_addr_s[2:0];
        word_addr_s = byte_addr_s[BW-1:3];
        last_col_s  = (col_r == COL_LAST);
        last_row_s  = (row_r == ROW_LAST);
        // The next pixel after a row end always starts a fresh word, so flush there too.
        flush_s     = (lane_s == 3'd7) | last_col_s;
        pixel_s     = sat_u8(output_fifo_data);
    end

    // Non-FWFT FIFO: data is valid the cycle after the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
        end
    end

    // Interior-pixel raster counters, wrapping at the frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= ROW_FIRST;
            col_r <= COL_FIRST;
        end else if (rd_valid_r) begin
            if (last_col_s) begin
                col_r <= COL_FIRST;
                if (last_row_s) begin
                    row_r <= ROW_FIRST;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Frame-done pulse aligned with the final flush of the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= rd_valid_r & last_col_s & last_row_s;
        end
    end

    assign frame_done = frame_done_r;

    byte_lane_packer #(
        .AW(AW)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .valid     (rd_valid_r),
        .flush     (flush_s),
        .lane      (lane_s),
        .pixel     (pixel_s),
        .word_addr (word_addr_s),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din)
    );

endmodule

// File: tb/tb_npu_output_collector.sv
// Directed bench for npu_output_collector: FIFO model, RAM write monitor and
// byte-level image reference, run on a 640x6 image to keep full frames short.
module tb_npu_output_collector;

    localparam int IMG_W     = 640;
    localparam int IMG_H     = 6;
    localparam int DATA_W    = 32;
    localparam int AW        = 16;
    localparam int ROW_PIX   = IMG_W - 2;
    localparam int FRAME_PIX = ROW_PIX * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              output_fifo_empty = 1'b1;
    logic [DATA_W-1:0] output_fifo_data = '0;
    logic              output_fifo_rd_en;
    logic [7:0]        ram_we;
    logic [AW-1:0]     ram_addr;
    logic [63:0]       ram_din;
    logic              frame_done;

    always #5 clk = ~clk;

    npu_output_collector #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .AW(AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .output_fifo_empty (output_fifo_empty),
        .output_fifo_data  (output_fifo_data),
        .output_fifo_rd_en (output_fifo_rd_en),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_din           (ram_din),
        .frame_done        (frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: empty recomputed each falling edge, data appears 1 ns after the reading edge.
    logic [31:0] fifo_q[$];
    bit          gap_en = 1'b0;

    initial begin
        logic [31:0] v;
        forever begin
            @(negedge clk);
            output_fifo_empty = (fifo_q.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
            @(posedge clk);
            if (output_fifo_rd_en) begin
                v = fifo_q.pop_front();
                #1 output_fifo_data = v;
            end
        end
    end

    // Write monitor.
    logic [7:0]    ram_bytes[int];
    logic [7:0]    exp_bytes[int];
    logic [7:0]    snap_bytes[int];
    int            wr_count, bad_mask, fd_count;
    logic [AW-1:0] first_addr, last_addr, fd_addr;
    logic [7:0]    first_we, last_we, fd_we;
    logic [63:0]   first_din, last_din;

    initial begin
        forever begin
            @(negedge clk);
            if (ram_we != 8'h00) begin
                if (wr_count == 0) begin
                    first_addr = ram_addr;
                    first_we   = ram_we;
                    first_din  = ram_din;
                end
                last_addr = ram_addr;
                last_we   = ram_we;
                last_din  = ram_din;
                wr_count++;
                for (int i = 0; i < 8; i++)
                    if (ram_we[i]) ram_bytes[int'(ram_addr) * 8 + i] = ram_din[8*i +: 8];
                if (!(ram_we inside {8'hFE, 8'h7F, 8'hFF})) bad_mask++;
            end
            if (frame_done) begin
                fd_count++;
                fd_addr = ram_addr;
                fd_we   = ram_we;
            end
        end
    end

    task automatic clear_mon();
        ram_bytes.delete();
        wr_count = 0;
        bad_mask = 0;
        fd_count = 0;
        first_addr = '0; last_addr = '0; fd_addr = '0;
        first_we = 8'h00; last_we = 8'h00; fd_we = 8'h00;
        first_din = 64'h0; last_din = 64'h0;
    endtask

    function automatic logic [31:0] gen(input int k);
        case (k % 4)
            0:       return 32'(k % 256);
            1:       return -32'(k);
            2:       return 32'(200 + k % 100);
            default: return 32'((k * 3) % 256);
        endcase
    endfunction

    function automatic logic [7:0] sat_ref(input logic [31:0] r);
        int s;
        s = $signed(r);
        if (s < 0) return 8'h00;
        else if (s > 255) return 8'hFF;
        else return 8'(s);
    endfunction

    function automatic int byte_of(input int k);
        return (1 + k / ROW_PIX) * IMG_W + 1 + k % ROW_PIX;
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while (fifo_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(n < 20000), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic cmp_img(input string tag, input bit use_snap);
        int diff = 0;
        if (use_snap) begin
            foreach (snap_bytes[a])
                if (!ram_bytes.exists(a) || ram_bytes[a] !== snap_bytes[a]) diff++;
            check({tag, "_size"}, 64'(ram_bytes.size()), 64'(snap_bytes.size()));
        end else begin
            foreach (exp_bytes[a])
                if (!ram_bytes.exists(a) || ram_bytes[a] !== exp_bytes[a]) diff++;
            check({tag, "_size"}, 64'(ram_bytes.size()), 64'(exp_bytes.size()));
        end
        check({tag, "_bytes"}, 64'(diff), 64'd0);
    endtask

    initial begin
        clear_mon();
        // Reset with a non-empty FIFO: no read may be issued.
        fifo_q.push_back(32'd99);
        repeat (3) @(negedge clk);
        check("rst_empty_low", 64'(output_fifo_empty), 64'd0);
        check("rst_rd_en", 64'(output_fifo_rd_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_din", ram_din, 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        fifo_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();

        // First word of row 1: (1,1)..(1,7) -> word 80 lanes 1..7; 17 stays pending.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'(10 + i));
        wait_drain("first");
        check("first_wr_count", 64'(wr_count), 64'd1);
        check("first_addr", 64'(first_addr), 64'd80);
        check("first_we", 64'(first_we), 64'hFE);
        check("first_din", first_din, 64'h100F0E0D0C0B0A00);

        // Saturation at cols 9..12, then the rest of row 1.
        fifo_q.push_back(32'hFFFF_FFFB);
        fifo_q.push_back(32'd300);
        fifo_q.push_back(32'd255);
        fifo_q.push_back(32'h8000_0000);
        for (int i = 0; i < ROW_PIX - 12; i++) fifo_q.push_back(gen(i));
        wait_drain("row1");
        check("sat_neg", 64'(ram_bytes[649]), 64'h00);
        check("sat_300", 64'(ram_bytes[650]), 64'hFF);
        check("sat_255", 64'(ram_bytes[651]), 64'hFF);
        check("sat_min", 64'(ram_bytes[652]), 64'h00);
        check("row1_pending17", 64'(ram_bytes[648]), 64'd17);
        check("row1_wr_count", 64'(wr_count), 64'd80);
        check("row_end_addr", 64'(last_addr), 64'd159);
        check("row_end_we", 64'(last_we), 64'h7F);
        check("row1_bad_mask", 64'(bad_mask), 64'd0);

        // Row 2 starts a fresh word at lane 1.
        for (int i = 0; i < 7; i++) fifo_q.push_back(32'(50 + i));
        wait_drain("row2");
        check("row2_addr", 64'(last_addr), 64'd160);
        check("row2_we", 64'(last_we), 64'hFE);
        check("row2_lane1", 64'(last_din[15:8]), 64'd50);
        check("row2_no_fd", 64'(fd_count), 64'd0);

        // Full gap-free frame.
        do_reset();
        exp_bytes.delete();
        for (int k = 0; k < FRAME_PIX; k++) begin
            fifo_q.push_back(gen(k));
            exp_bytes[byte_of(k)] = sat_ref(gen(k));
        end
        wait_drain("frame");
        check("frame_fd_count", 64'(fd_count), 64'd1);
        check("frame_fd_addr", 64'(fd_addr), 64'd399);
        check("frame_fd_we", 64'(fd_we), 64'h7F);
        check("frame_wr_count", 64'(wr_count), 64'd320);
        cmp_img("frame_img", 1'b0);
        snap_bytes = ram_bytes;

        // Wrap to (1,1) after the frame.
        for (int i = 0; i < 7; i++) fifo_q.push_back(32'(90 + i));
        wait_drain("wrap");
        check("wrap_addr", 64'(last_addr), 64'd80);
        check("wrap_we", 64'(last_we), 64'hFE);
        check("wrap_lane1", 64'(last_din[15:8]), 64'd90);
        check("wrap_fd_count", 64'(fd_count), 64'd1);

        // Reset after 5 results of row 1: the partial word is dropped.
        do_reset();
        for (int k = 0; k < 5; k++) fifo_q.push_back(32'(20 + k));
        wait_drain("partial");
        check("partial_no_write", 64'(wr_count), 64'd0);
        do_reset();

        // Frame with random FIFO gaps must reproduce the gap-free image.
        gap_en = 1'b1;
        for (int k = 0; k < FRAME_PIX; k++) fifo_q.push_back(gen(k));
        wait_drain("gaps");
        gap_en = 1'b0;
        check("gaps_first_addr", 64'(first_addr), 64'd80);
        check("gaps_first_we", 64'(first_we), 64'hFE);
        check("gaps_first_lane1", 64'(first_din[15:8]), 64'(sat_ref(gen(0))));
        check("gaps_first_lane3", 64'(first_din[31:24]), 64'(sat_ref(gen(2))));
        check("gaps_fd_count", 64'(fd_count), 64'd1);
        check("gaps_bad_mask", 64'(bad_mask), 64'd0);
        cmp_img("gaps_img", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
